rv32_uart_tx: RTL and testbench
===============================

Name: rv32_uart_tx

Overview:
Memory-mapped UART transmitter that sits directly downstream of rv32_top on its data bus. It gives the core a console output channel. Store data written by the core is buffered in a small FIFO and serialised as 8N1 frames on tx_o. Bus reads return status so firmware can poll before writing.

Parameters:
FIFO_DEPTH, 8, TX FIFO depth in bytes; power of two, 2..64
DEFAULT_DIV, 16'd868, reset value of BAUD_DIV (clk cycles per bit)

Ports:
clk_sys_i  input  1  system clock, all logic on rising edge
rst_n_i  input  1  asynchronous active-low reset
sel_i  input  1  peripheral selected by core address decode
addr_i  input  4  byte offset; only 0x0, 0x4, 0x8 decoded
we_i  input  1  write strobe, qualified by sel_i
re_i  input  1  read strobe, qualified by sel_i
wdata_i  input  32  write data
rdata_o  output  32  registered read data
tx_o  output  1  serial line, idle high
irq_o  output  1  level interrupt: FIFO empty and TX idle, masked by CTRL.ie

Behaviour:
- Reset (async, rst_n_i low): tx_o=1, rdata_o=0, irq_o=0, FIFO empty (pointers 0), FSM=IDLE, BAUD_DIV=DEFAULT_DIV, overflow=0, ie=0. Releasing reset causes no glitch on tx_o.
- Register map:
  - 0x0 TXDATA (W): push wdata_i[7:0]. Reads return 0.
  - 0x4 STATUS/CTRL (R):
    - bit0 full
    - bit1 empty
    - bit2 busy (FSM not IDLE)
    - bit3 overflow (sticky)
    - bit4 ie
    - bits[15:8] FIFO count
  - 0x4 STATUS/CTRL (W): writing 1 to bit3 clears overflow; bit4 writes ie.
  - 0x8 BAUD_DIV (R/W, bits[15:0]). A written value of 0 is stored as 1.
  - Undecoded offsets: writes are ignored; reads return 0.
- Bus timing: a write takes effect at the clock edge where sel_i&we_i is high. For a read, rdata_o is valid on the cycle after sel_i&re_i and holds until the next read. No wait states.
- FIFO:
  - Push when full: the byte is dropped and overflow is set.
  - Push and pop in the same cycle while full: the pop frees space first, the push is accepted, and overflow is not set.
  - Push while empty and IDLE: the byte is popped no earlier than the next cycle.
  - Count is width clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- TX FSM:
  - IDLE: tx_o=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: tx_o=0 for one bit period.
  - DATA: 8 bits, LSB first, one bit period each.
  - STOP: tx_o=1 for one bit period. Then pop the next byte directly into START if the FIFO is non-empty (back-to-back frames, no extra idle), else go to IDLE.
- Bit timing:
  - Bit period = BAUD_DIV cycles, counted by a 16-bit down-counter reloaded at each bit boundary.
  - A BAUD_DIV write mid-frame takes effect at the next bit boundary. The current bit completes with the old count.
- Frame length: exactly 10*BAUD_DIV cycles. From a push into an empty idle FIFO, tx_o first falls 2 cycles after the write edge.
- irq_o: registered, = ie & empty & ~busy. It updates one cycle after the condition changes.
- Reset mid-frame: tx_o returns to 1 immediately (async). The frame is truncated and FIFO contents are lost.

Test Plan:
- Reset then idle 50 cycles -> tx_o=1, STATUS read = 0x0000_0002, BAUD_DIV read = 0x364.
- BAUD_DIV=4, write TXDATA 0x55 -> tx_o sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles (40 cycles total); busy=1 during the frame; tx_o returns to 1.
- BAUD_DIV=2, write 0xA5 and 0x3C back-to-back -> two contiguous 20-cycle frames, no idle gap; STATUS count reads 1 during the first frame.
- FIFO_DEPTH=8, BAUD_DIV=100, 10 rapid writes -> first byte popped, 8 queued, 10th dropped; STATUS full=1, overflow=1; write 0x8 to STATUS -> overflow=0.
- ie=1, single byte at BAUD_DIV=3 -> irq_o=0 while transmitting; irq_o=1 exactly one cycle after the FSM reaches IDLE with the FIFO empty.
- Assert rst_n_i during DATA bit 3 -> tx_o=1 asynchronously; after release, STATUS=0x2 and no residual frame.

Source files
------------

// File: rtl/rv32_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO fed by core stores, serialised on tx_o.
// STATUS/CTRL and BAUD_DIV registers let firmware poll, enable the idle interrupt and set the bit rate.
module rv32_uart_tx #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk_sys_i,
  input  logic        rst_n_i,
  input  logic        sel_i,
  input  logic [3:0]  addr_i,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   baud_div;
  logic [15:0]   baud_cnt;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic          overflow;
  logic          ie;

  logic          wr_txdata, wr_ctrl, wr_baud, rd_en;
  logic          full, empty, busy, bit_done, pop, push_ok;
  logic [31:0]   rd_mux;
  logic          unused_wdata;

  assign wr_txdata = sel_i & we_i & (addr_i == 4'h0);
  assign wr_ctrl   = sel_i & we_i & (addr_i == 4'h4);
  assign wr_baud   = sel_i & we_i & (addr_i == 4'h8);
  assign rd_en     = sel_i & re_i;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign busy     = (state != IDLE);
  assign bit_done = (baud_cnt == 16'd0);

  // The FSM pops from IDLE, or at the end of a stop bit for back-to-back frames.
  // A same-cycle pop frees a slot, so a push into a full FIFO is still accepted.
  assign pop     = !empty && ((state == IDLE) || ((state == STOP) && bit_done));
  assign push_ok = wr_txdata && (!full || pop);

  assign unused_wdata = &{1'b0, wdata_i[31:16]};

  always_ff @(posedge clk_sys_i) begin
    if (push_ok) mem[wr_ptr] <= wdata_i[7:0];
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      baud_div <= DEFAULT_DIV;
      ie       <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_baud) baud_div <= (wdata_i[15:0] == 16'd0) ? 16'd1 : wdata_i[15:0];
      if (wr_ctrl) ie <= wdata_i[4];
      // A dropped byte in the same cycle as a clear leaves the flag set.
      if (wr_txdata && full && !pop)   overflow <= 1'b1;
      else if (wr_ctrl && wdata_i[3])  overflow <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = 32'h0;
    case (addr_i)
      4'h4:    rd_mux = {16'h0, 8'(count), 3'b000, ie, overflow, busy, empty, full};
      4'h8:    rd_mux = {16'h0, baud_div};
      default: rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_o <= 32'h0;
      irq_o   <= 1'b0;
    end else begin
      if (rd_en) rdata_o <= rd_mux;
      irq_o <= ie & empty & ~busy;
    end
  end

  // tx_o is registered from the current state, so the line trails the FSM by one cycle.
  // baud_div is sampled only on reload, so a mid-frame change lands at the next bit boundary.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      baud_cnt <= 16'd0;
      shreg    <= 8'h0;
      bit_idx  <= 3'd0;
      tx_o     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            shreg    <= mem[rd_ptr];
            baud_cnt <= baud_div - 16'd1;
            state    <= START;
          end
        end
        START: begin
          if (bit_done) begin
            baud_cnt <= baud_div - 16'd1;
            bit_idx  <= 3'd0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= baud_div - 16'd1;
            shreg    <= shreg >> 1;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            baud_cnt <= baud_div - 16'd1;
            if (!empty) begin
              shreg <= mem[rd_ptr];
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase

      case (state)
        START:   tx_o <= 1'b0;
        DATA:    tx_o <= shreg[0];
        default: tx_o <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_uart_tx.sv
// Bench for rv32_uart_tx: bus driver tasks, a line monitor that decodes 8N1 frames,
// and a byte scoreboard fed when TXDATA is written.
module tb_rv32_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel, we, re;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  int          cyc = 0;
  int          tests = 0;
  int          failed = 0;
  int          wr_cyc = 0;
  int          frame_cnt = 0;
  int          cur_div = 868;
  logic [7:0]  exp_q[$];
  int          starts[$];

  // monitor state
  logic        prev;
  logic [9:0]  bits;
  logic        stable, aborted;
  int          sc, d;
  logic [7:0]  e;

  rv32_uart_tx dut (
    .clk_sys_i (clk),
    .rst_n_i   (rst_n),
    .sel_i     (sel),
    .addr_i    (addr),
    .we_i      (we),
    .re_i      (re),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .tx_o      (tx),
    .irq_o     (irq)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // driver tasks: called on a falling edge, return on the falling edge after the bus edge
  task automatic bus_write(input logic [3:0] a, input logic [31:0] dat);
    sel = 1'b1; we = 1'b1; addr = a; wdata = dat;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
    wr_cyc = cyc;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] dat);
    sel = 1'b1; re = 1'b1; addr = a;
    @(negedge clk);
    sel = 1'b0; re = 1'b0;
    dat = rdata;
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_q.push_back(b);
    bus_write(4'h0, {24'h0, b});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int k;
    k = 0;
    while (frame_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_frames", frame_cnt, target);
  endtask

  // line monitor: one sample per cycle, each bit must hold cur_div cycles
  initial begin
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b1;
      end else if (prev && !tx) begin
        sc = cyc; d = cur_div; bits = '0; stable = 1'b1; aborted = 1'b0;
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int c = 0; c < d && !aborted; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (!rst_n)      aborted = 1'b1;
            else if (c == 0) bits[b] = tx;
            else if (tx !== bits[b]) stable = 1'b0;
          end
        end
        if (aborted) begin
          prev = 1'b1;
        end else begin
          frame_cnt++;
          starts.push_back(sc);
          check("frame_stable", {31'h0, stable}, 32'h1);
          check("frame_stop", {31'h0, bits[9]}, 32'h1);
          check("sb_has_exp", {31'h0, exp_q.size() != 0}, 32'h1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("frame_data", {24'h0, bits[8:1]}, {24'h0, e});
          end
          prev = tx;
        end
      end else begin
        prev = tx;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish by 2ms");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] st;
    int w, fc0;
    rst_n = 1'b0; sel = 1'b0; we = 1'b0; re = 1'b0; addr = 4'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'h0, tx}, 32'h1);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;

    // reset state after a quiet period
    idle(50);
    check("t1_tx", {31'h0, tx}, 32'h1);
    bus_read(4'h4, st); check("t1_status", st, 32'h0000_0002);
    bus_read(4'h8, st); check("t1_baud", st, 32'h0000_0364);

    // single frame, 0x55 at 4 cycles per bit
    bus_write(4'h8, 32'd4); cur_div = 4;
    starts.delete(); fc0 = frame_cnt;
    push_byte(8'h55); w = wr_cyc;
    idle(10);
    bus_read(4'h4, st); check("t2_busy", {31'h0, st[2]}, 32'h1);
    wait_frames(fc0 + 1, 100);
    check("t2_starts", starts.size(), 1);
    if (starts.size() == 1) check("t2_latency", starts[0] - w, 2);
    idle(2);
    check("t2_tx_idle", {31'h0, tx}, 32'h1);
    bus_read(4'h4, st); check("t2_status_done", st, 32'h0000_0002);

    // back-to-back frames at 2 cycles per bit
    bus_write(4'h8, 32'd2); cur_div = 2;
    starts.delete(); fc0 = frame_cnt;
    push_byte(8'hA5);
    push_byte(8'h3C);
    bus_read(4'h4, st); check("t3_count", {24'h0, st[15:8]}, 32'h1);
    wait_frames(fc0 + 2, 100);
    check("t3_starts", starts.size(), 2);
    if (starts.size() == 2) check("t3_gap", starts[1] - starts[0], 20);

    // overflow: one popped, eight queued, tenth dropped
    bus_write(4'h8, 32'd100); cur_div = 100;
    fc0 = frame_cnt;
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      if (i < 9) exp_q.push_back(b);
      bus_write(4'h0, {24'h0, b});
    end
    bus_read(4'h4, st); check("t4_full_ovf", st, 32'h0000_080D);
    bus_write(4'h4, 32'h8);
    bus_read(4'h4, st); check("t4_ovf_clear", st, 32'h0000_0805);
    wait_frames(fc0 + 9, 9400);
    bus_read(4'h4, st); check("t4_drained", st, 32'h0000_0002);

    // interrupt timing at 3 cycles per bit
    bus_write(4'h8, 32'd3); cur_div = 3;
    bus_write(4'h4, 32'h10);
    idle(2);
    check("t5_irq_idle", {31'h0, irq}, 32'h1);
    fc0 = frame_cnt;
    push_byte(8'($urandom_range(0, 255))); w = wr_cyc;
    idle(10);
    check("t5_irq_mid", {31'h0, irq}, 32'h0);
    idle(21);
    check("t5_irq_pre", {31'h0, irq}, 32'h0);
    idle(1);
    check("t5_irq_rise", {31'h0, irq}, 32'h1);
    wait_frames(fc0 + 1, 50);
    bus_write(4'h4, 32'h0);
    idle(2);
    check("t5_irq_masked", {31'h0, irq}, 32'h0);

    // decode corners
    bus_write(4'h8, 32'h0);
    bus_read(4'h8, st); check("baud_zero", st, 32'h1);
    bus_read(4'hC, st); check("rd_undecoded", st, 32'h0);
    bus_read(4'h0, st); check("rd_txdata", st, 32'h0);
    bus_write(4'hC, 32'hFFFF_FFFF);
    bus_read(4'h4, st); check("wr_undecoded_status", st, 32'h0000_0002);
    bus_read(4'h8, st); check("wr_undecoded_baud", st, 32'h1);

    // reset during data bit 3
    bus_write(4'h8, 32'd4); cur_div = 4;
    push_byte(8'hF0); w = wr_cyc;
    push_byte(8'h81);
    idle(w + 19 - cyc);
    check("t6_pre_low", {31'h0, tx}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("t6_async_tx", {31'h0, tx}, 32'h1);
    idle(3);
    rst_n = 1'b1;
    exp_q.delete(); cur_div = 868;
    fc0 = frame_cnt;
    idle(2);
    bus_read(4'h4, st); check("t6_status", st, 32'h0000_0002);
    bus_read(4'h8, st); check("t6_baud", st, 32'h0000_0364);
    idle(50);
    check("t6_tx_quiet", {31'h0, tx}, 32'h1);
    check("t6_no_frame", frame_cnt, fc0);

    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
